// File: rtl/csr_addr_fifo.sv
// Multi-entry CSR address FIFO between the CSR issue port and commit.
// Holds in-flight CSR addresses in program order; optional CFI landing-pad remap.
package csr_addr_fifo_pkg;
  localparam int XLEN = 64;
  typedef logic [XLEN-1:0] xlen_t;

  typedef enum logic [3:0] {
    CSR_READ,
    CSR_WRITE,
    CSR_SET,
    CSR_CLEAR,
    LPSLL,
    LPSML,
    LPSUL,
    LPCLL,
    ADD
  } fu_op_e;

  typedef struct packed {
    fu_op_e operation;
    xlen_t  operand_a;
    xlen_t  operand_b;
  } fu_data_t;

  localparam logic [11:0] CSR_LPLR = 12'h806;
  localparam logic [11:0] CSR_ELP  = 12'h807;
endpackage

module csr_addr_fifo
  import csr_addr_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter bit          CFI_EN = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  fu_data_t                   fu_data_i,
  input  logic                       csr_valid_i,
  output logic                       csr_ready_o,
  output xlen_t                      csr_result_o,
  input  logic                       csr_commit_i,
  output logic [11:0]                csr_addr_o,
  output logic                       csr_addr_valid_o,
  output logic [$clog2(DEPTH+1)-1:0] csr_count_o,
  output logic                       commit_err_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  // Handshake: a request transfers on a cycle where csr_valid_i and csr_ready_o
  // are both high and flush_i is low; ready never looks at valid.

  logic [11:0]   mem_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic          err_q;
  logic          empty, push, pop;
  logic [11:0]   push_addr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  assign empty       = (count_q == '0);
  assign csr_ready_o = (count_q < DEPTH_C) | csr_commit_i;
  assign push        = csr_valid_i & csr_ready_o & ~flush_i;
  assign pop         = csr_commit_i & ~empty & ~flush_i;

  always_comb begin
    push_addr = fu_data_i.operand_b[11:0];
    if (CFI_EN) begin
      unique case (fu_data_i.operation)
        LPSLL, LPSML, LPSUL: push_addr = CSR_LPLR;
        LPCLL:               push_addr = CSR_ELP;
        default:             push_addr = fu_data_i.operand_b[11:0];
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      // Array contents are left stale; count 0 hides them.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) begin
        mem_q[tail_q] <= push_addr;
        tail_q        <= next_ptr(tail_q);
      end
      if (pop) head_q <= next_ptr(head_q);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      err_q <= csr_commit_i & empty;
    end
  end

  assign csr_result_o     = fu_data_i.operand_a;
  assign csr_addr_o       = empty ? 12'h000 : mem_q[head_q];
  assign csr_addr_valid_o = ~empty;
  assign csr_count_o      = count_q;
  assign commit_err_o     = err_q;
endmodule
